// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier scheduler and its step datapath.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_e;

  // Radix-2 recoding of the {Q[0], Q_-1} bit pair.
  function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
    booth_op_e op;
    case ({q0, q_m1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mult_scheduler_if.sv
// Two-requester operand bus plus response channel of the shared Booth multiplier.
interface booth_mult_scheduler_if #(
  parameter int WIDTH = booth_pkg::DEFAULT_WIDTH
);
  logic               req0Valid;
  logic [WIDTH-1:0]   req0A;
  logic [WIDTH-1:0]   req0B;
  logic               req0Ready;
  logic               req1Valid;
  logic [WIDTH-1:0]   req1A;
  logic [WIDTH-1:0]   req1B;
  logic               req1Ready;
  logic               respValid;
  logic               respReady;
  logic               respId;
  logic [2*WIDTH-1:0] respProduct;
  logic               busy;

  // Client side: requesters and the product consumer.
  modport master (
    output req0Valid, req0A, req0B, req1Valid, req1A, req1B, respReady,
    input  req0Ready, req1Ready, respValid, respId, respProduct, busy
  );

  // Multiplier side.
  modport slave (
    input  req0Valid, req0A, req0B, req1Valid, req1A, req1B, respReady,
    output req0Ready, req1Ready, respValid, respId, respProduct, busy
  );
endinterface

// File: rtl/booth_radix2_step.sv
// One combinational radix-2 Booth iteration: conditional add/sub of M, then
// arithmetic right shift of {acc, Q, Q_-1}.
module booth_radix2_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    case (booth_decode(q[0], q_m1))
      OP_ADD:  sum = acc + m;
      OP_SUB:  sum = acc - m;
      default: sum = acc;
    endcase
    acc_next  = {sum[WIDTH], sum[WIDTH:1]};
    q_next    = {sum[0], q[WIDTH-1:1]};
    q_m1_next = q[0];
  end

endmodule

// File: rtl/booth_mult_scheduler.sv
// Round-robin front end sharing one iterative radix-2 Booth signed multiplier
// between two requesters; product is returned tagged with the requester ID.
module booth_mult_scheduler
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                   clk,
  input logic                   reset,
  booth_mult_scheduler_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_reg, state_next;
  logic [WIDTH:0]     acc_reg;
  logic [WIDTH:0]     m_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q_m1_reg;
  logic [CW-1:0]      count_reg;
  logic               id_reg;
  logic               last_grant_reg;
  logic               resp_id_reg;
  logic [2*WIDTH-1:0] product_reg;

  logic [WIDTH:0]     acc_step;
  logic [WIDTH-1:0]   q_step;
  logic               q_m1_step;
  logic               grant;
  logic [1:0]         ready;
  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  booth_radix2_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc_reg),
    .q         (q_reg),
    .q_m1      (q_m1_reg),
    .m         (m_reg),
    .acc_next  (acc_step),
    .q_next    (q_step),
    .q_m1_next (q_m1_step)
  );

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant = 1'b0;
    case ({bus.req1Valid, bus.req0Valid})
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_reg;
      default: grant = 1'b0;
    endcase
  end

  assign sel_a = grant ? bus.req1A : bus.req0A;
  assign sel_b = grant ? bus.req1B : bus.req0B;

  always_comb begin
    state_next = state_reg;
    ready      = 2'b00;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        ready[0] = bus.req0Valid & ~grant;
        ready[1] = bus.req1Valid & grant;
        accept   = |ready;
        if (accept) state_next = ITER;
      end
      ITER: begin
        last_step = (count_reg == CW'(1));
        if (last_step) state_next = DONE;
      end
      DONE: begin
        if (bus.respReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.req0Ready   = ready[0];
  assign bus.req1Ready   = ready[1];
  assign bus.respValid   = (state_reg == DONE);
  assign bus.respId      = resp_id_reg;
  assign bus.respProduct = product_reg;
  assign bus.busy        = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg        <= '0;
      m_reg          <= '0;
      q_reg          <= '0;
      q_m1_reg       <= 1'b0;
      count_reg      <= '0;
      id_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
      resp_id_reg    <= 1'b0;
      product_reg    <= '0;
    end else if (accept) begin
      m_reg          <= {sel_a[WIDTH-1], sel_a};
      q_reg          <= sel_b;
      q_m1_reg       <= 1'b0;
      acc_reg        <= '0;
      count_reg      <= CW'(WIDTH);
      id_reg         <= grant;
      last_grant_reg <= grant;
    end else if (state_reg == ITER) begin
      acc_reg   <= acc_step;
      q_reg     <= q_step;
      q_m1_reg  <= q_m1_step;
      count_reg <= count_reg - CW'(1);
      // Response registers are separate so they survive the next job's iterations.
      if (last_step) begin
        product_reg <= {acc_step[WIDTH-1:0], q_step};
        resp_id_reg <= id_reg;
      end
    end
  end

endmodule
